keycode_report_builder: RTL and testbench
=========================================

# keycode_report_builder

Maintains a six-slot USB HID-style keycode report from a stream of individual key press/release events and drives the packed 48-bit `keycodes` bus consumed by the game's key decoder. It sits between the event source (a scripted/demo input player or host-side event bridge) and the character-control decode logic. Slots are kept packed from slot 0 upward in press order, with released keys compacted out. A full report is handled either by dropping the event or by entering HID phantom (ErrorRollOver) state, depending on configuration.

## Interface
Parameters:
- `ROLLOVER_CODE`, 8'h01: keycode reported in every slot during phantom state.
- `OVF_MAX`, 7: saturation limit of the overflow counter (3-bit).

Ports:
- `Clk`  in  1  system clock; all state changes on rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `ev_valid`  in  1  event offered.
- `ev_ready`  out  1  block can accept an event (high only in IDLE).
- `ev_keycode`  in  8  HID usage code of the event.
- `ev_press`  in  1  1 = press, 0 = release.
- `keycodes`  out  48  report; slot n at `[8n+7:8n]`, unused slots 8'h00.
- `key_count`  out  3  number of occupied slots, 0..6.
- `report_changed`  out  1  one-cycle pulse in the cycle a new `keycodes` value first appears.
- `overflow`  out  1  one-cycle pulse when a press finds the report full.

## Operation
- States: IDLE, SCAN, COMMIT.
- IDLE: `ev_ready`=1. On `ev_valid && ev_ready`, latch `ev_keycode`/`ev_press`, clear match/free trackers, set scan index 0, go to SCAN.
- SCAN: one slot per cycle, index 0..5. Record the first slot equal to the latched code (match index). Index 5 → COMMIT.
- COMMIT: apply the update, go to IDLE.
  - Press, match found: no change.
  - Press, no match, `key_count`<6: write code into slot `key_count`, increment.
  - Press, no match, `key_count`=6: pulse `overflow`; see Configuration.
  - Release, match at slot m: slots m+1..5 shift down one; slot 5 ← 8'h00; decrement count.
  - Release, no match: no slot change; see Configuration.
- A latched keycode of 8'h00 is accepted and makes no change (no `report_changed`, no `overflow`).
- `report_changed` pulses only if the driven `keycodes` value actually differs from its previous value.
- Reset (any state, including mid-SCAN): all slots 8'h00, `key_count`=0, overflow counter 0, state IDLE. `keycodes`=0, `report_changed`=0, `overflow`=0, and `ev_ready`=0 during the reset cycle. `ev_ready`=1 from the first cycle after `Reset` deasserts. An in-flight event is discarded.

## Timing
- Handshake edge T0. Scan edges T1–T6. Commit edge T7.
- New `keycodes`/`key_count`, `report_changed`, `overflow`, and `ev_ready`=1 are all visible in the cycle after T7.
- Latency is 7 cycles. Maximum throughput is one event per 8 cycles.
- `ev_keycode`/`ev_press` need only be stable at the handshake edge.
- `keycodes`, `key_count`, `report_changed`, and `overflow` are registered outputs.
- `ev_ready` is decoded from state.

## Configuration
- Macro: `KEYREPORT_ROLLOVER_EN`.
- Defined:
  - A full-report press increments the overflow counter, saturating at `OVF_MAX`.
  - While the counter >0, `keycodes` drives `ROLLOVER_CODE` in all six slots. `key_count` still reflects the true slot occupancy.
  - A no-match release decrements the counter if >0.
  - A matched release compacts the slots normally; the output stays phantom while the counter >0.
  - The counter reaching 0 restores the slot array onto `keycodes`, with a `report_changed` pulse.
- Not defined:
  - A full-report press is dropped; the `overflow` pulse still occurs.
  - No-match releases are ignored.
  - No overflow counter is built.

## Test plan
- Reset, then press 0x04, 0x07, 0x1A → `keycodes`=48'h00_00_00_1A_07_04, `key_count`=3, three `report_changed` pulses, each 7 cycles after its handshake.
- From that state, release 0x07 → `keycodes`=48'h00_00_00_00_1A_04, `key_count`=2. Then press 0x04 again → no change and no `report_changed`.
- Press 0x04, 0x07, 0x1A, 0x16, 0x50, 0x4F, then 0x52 → `overflow` pulse.
  - Without the macro: `keycodes`=48'h4F_50_16_1A_07_04.
  - With the macro: `keycodes`=48'h01_01_01_01_01_01; releasing 0x52 restores the six-key report.
- Hold `ev_valid` high with events back to back → `ev_ready` low for exactly 7 cycles after each handshake, and exactly one event accepted per 8 cycles.
- Assert `Reset` during SCAN of a press of 0x1A with 2 keys held → the next cycle shows `keycodes`=0, `key_count`=0, `ev_ready`=0; the event is lost and `ev_ready`=1 after deassert.
- Release 0x22 on an empty report, and press 0x00 → no change, no pulses, `ev_ready` back after 7 cycles.

Source files
------------

// File: rtl/keycode_report_builder.sv
// Six-slot HID keycode report built from press/release events, one slot scanned per cycle.
// Define KEYREPORT_ROLLOVER_EN for HID ErrorRollOver phantom reporting on a full report.
module keycode_report_builder #(
    parameter logic [7:0]  ROLLOVER_CODE = 8'h01,
    parameter int unsigned OVF_MAX       = 7
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        ev_valid,
    output logic        ev_ready,
    input  logic [7:0]  ev_keycode,
    input  logic        ev_press,
    output logic [47:0] keycodes,
    output logic [2:0]  key_count,
    output logic        report_changed,
    output logic        overflow
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SCAN   = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;

    localparam logic [2:0] LAST_IDX  = 3'd5;
    localparam logic [2:0] NUM_SLOTS = 3'd6;

    logic [1:0]      state_q, state_d;
    logic [7:0]      code_q, code_d;
    logic            press_q, press_d;
    logic [2:0]      idx_q, idx_d;
    logic            hit_q, hit_d;
    logic [2:0]      hit_idx_q, hit_idx_d;
    logic [5:0][7:0] slots_q, slots_d;
    logic [5:0][7:0] shifted;
    logic [2:0]      count_q, count_d;
    logic [47:0]     out_q, out_d;
    logic            chg_q, chg_d;
    logic            ovf_pls_q, ovf_pls_d;
    logic            rst_q;

`ifdef KEYREPORT_ROLLOVER_EN
    logic [2:0] ovf_cnt_q, ovf_cnt_d;
`else
    logic unused_params;
    assign unused_params = ^{ROLLOVER_CODE, 3'(OVF_MAX)};
`endif

    // Held low for the cycle after a reset edge so no event slips in mid-reset.
    assign ev_ready       = (state_q == S_IDLE) && !rst_q;
    assign keycodes       = out_q;
    assign key_count      = count_q;
    assign report_changed = chg_q;
    assign overflow       = ovf_pls_q;

    assign shifted = {8'h00, slots_q[5:1]};

    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        press_d   = press_q;
        idx_d     = idx_q;
        hit_d     = hit_q;
        hit_idx_d = hit_idx_q;
        slots_d   = slots_q;
        count_d   = count_q;
        ovf_pls_d = 1'b0;
`ifdef KEYREPORT_ROLLOVER_EN
        ovf_cnt_d = ovf_cnt_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (ev_valid && ev_ready) begin
                    code_d    = ev_keycode;
                    press_d   = ev_press;
                    hit_d     = 1'b0;
                    hit_idx_d = 3'd0;
                    idx_d     = 3'd0;
                    state_d   = S_SCAN;
                end
            end

            S_SCAN: begin
                if (!hit_q && (slots_q[idx_q] == code_q)) begin
                    hit_d     = 1'b1;
                    hit_idx_d = idx_q;
                end
                if (idx_q == LAST_IDX) begin
                    state_d = S_COMMIT;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end

            S_COMMIT: begin
                state_d = S_IDLE;
                if (code_q != 8'h00) begin
                    if (press_q) begin
                        if (!hit_q) begin
                            if (count_q < NUM_SLOTS) begin
                                slots_d[count_q] = code_q;
                                count_d          = count_q + 3'd1;
                            end else begin
                                ovf_pls_d = 1'b1;
`ifdef KEYREPORT_ROLLOVER_EN
                                if (ovf_cnt_q != 3'(OVF_MAX)) begin
                                    ovf_cnt_d = ovf_cnt_q + 3'd1;
                                end
`endif
                            end
                        end
                    end else if (hit_q) begin
                        for (int i = 0; i < 6; i++) begin
                            if (3'(i) >= hit_idx_q) begin
                                slots_d[i] = shifted[i];
                            end
                        end
                        count_d = count_q - 3'd1;
                    end else begin
`ifdef KEYREPORT_ROLLOVER_EN
                        if (ovf_cnt_q != 3'd0) begin
                            ovf_cnt_d = ovf_cnt_q - 3'd1;
                        end
`endif
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef KEYREPORT_ROLLOVER_EN
        out_d = (ovf_cnt_d != 3'd0) ? {6{ROLLOVER_CODE}} : slots_d;
`else
        out_d = slots_d;
`endif
        // Slots only move at commit, so this is a commit-time compare.
        chg_d = (out_d != out_q);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            code_q    <= 8'h00;
            press_q   <= 1'b0;
            idx_q     <= 3'd0;
            hit_q     <= 1'b0;
            hit_idx_q <= 3'd0;
            slots_q   <= '0;
            count_q   <= 3'd0;
            out_q     <= 48'h0;
            chg_q     <= 1'b0;
            ovf_pls_q <= 1'b0;
            rst_q     <= 1'b1;
`ifdef KEYREPORT_ROLLOVER_EN
            ovf_cnt_q <= 3'd0;
`endif
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            press_q   <= press_d;
            idx_q     <= idx_d;
            hit_q     <= hit_d;
            hit_idx_q <= hit_idx_d;
            slots_q   <= slots_d;
            count_q   <= count_d;
            out_q     <= out_d;
            chg_q     <= chg_d;
            ovf_pls_q <= ovf_pls_d;
            rst_q     <= 1'b0;
`ifdef KEYREPORT_ROLLOVER_EN
            ovf_cnt_q <= ovf_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_keycode_report_builder.sv
// Directed bench for keycode_report_builder; honours KEYREPORT_ROLLOVER_EN.
module tb_keycode_report_builder;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        ev_valid;
    logic        ev_ready;
    logic [7:0]  ev_keycode;
    logic        ev_press;
    logic [47:0] keycodes;
    logic [2:0]  key_count;
    logic        report_changed;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    keycode_report_builder dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .ev_valid       (ev_valid),
        .ev_ready       (ev_ready),
        .ev_keycode     (ev_keycode),
        .ev_press       (ev_press),
        .keycodes       (keycodes),
        .key_count      (key_count),
        .report_changed (report_changed),
        .overflow       (overflow)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 20 && ev_ready !== 1'b1; i++) @(negedge Clk);
        chk("ready_wait", 48'(ev_ready), 48'd1);
    endtask

    // Called at a negedge; returns at the negedge after the commit edge.
    task automatic send(input string tag, input logic [7:0] c, input logic p,
                        input logic exp_chg, input logic exp_ovf);
        int lowc;
        int early;
        lowc  = 0;
        early = 0;
        wait_ready();
        ev_valid   = 1'b1;
        ev_keycode = c;
        ev_press   = p;
        @(negedge Clk);
        ev_valid   = 1'b0;
        ev_keycode = 8'($urandom);
        ev_press   = 1'($urandom);
        for (int k = 0; k < 7; k++) begin
            if (ev_ready === 1'b0) lowc++;
            if (report_changed !== 1'b0 || overflow !== 1'b0) early++;
            @(negedge Clk);
        end
        chk({tag, "_busy"}, 48'(lowc), 48'd7);
        chk({tag, "_early"}, 48'(early), 48'd0);
        chk({tag, "_rdy"}, 48'(ev_ready), 48'd1);
        chk({tag, "_chg"}, 48'(report_changed), 48'(exp_chg));
        chk({tag, "_ovf"}, 48'(overflow), 48'(exp_ovf));
    endtask

    initial begin
        int n;
        int first;
        int last;

        Reset      = 1'b1;
        ev_valid   = 1'b0;
        ev_keycode = 8'h00;
        ev_press   = 1'b0;
        @(negedge Clk);
        chk("rst_kc", keycodes, 48'h0);
        chk("rst_cnt", 48'(key_count), 48'd0);
        chk("rst_rdy", 48'(ev_ready), 48'd0);
        chk("rst_chg", 48'(report_changed), 48'd0);
        chk("rst_ovf", 48'(overflow), 48'd0);
        Reset = 1'b0;
        @(negedge Clk);
        chk("rst_rdy_after", 48'(ev_ready), 48'd1);

        send("p04", 8'h04, 1'b1, 1'b1, 1'b0);
        send("p07", 8'h07, 1'b1, 1'b1, 1'b0);
        send("p1A", 8'h1A, 1'b1, 1'b1, 1'b0);
        chk("three_kc", keycodes, 48'h00_00_00_1A_07_04);
        chk("three_cnt", 48'(key_count), 48'd3);
        @(negedge Clk);
        chk("chg_one_cycle", 48'(report_changed), 48'd0);

        send("r07", 8'h07, 1'b0, 1'b1, 1'b0);
        chk("rel_kc", keycodes, 48'h00_00_00_00_1A_04);
        chk("rel_cnt", 48'(key_count), 48'd2);
        send("p04dup", 8'h04, 1'b1, 1'b0, 1'b0);
        chk("dup_kc", keycodes, 48'h00_00_00_00_1A_04);

        // Reset lands mid-scan; the event must be lost.
        wait_ready();
        ev_valid   = 1'b1;
        ev_keycode = 8'h1A;
        ev_press   = 1'b1;
        @(negedge Clk);
        ev_valid = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        chk("mid_kc", keycodes, 48'h0);
        chk("mid_cnt", 48'(key_count), 48'd0);
        chk("mid_rdy", 48'(ev_ready), 48'd0);
        Reset = 1'b0;
        @(negedge Clk);
        chk("mid_rdy_after", 48'(ev_ready), 48'd1);
        n = 0;
        for (int k = 0; k < 10; k++) begin
            if (report_changed !== 1'b0) n++;
            @(negedge Clk);
        end
        chk("mid_lost_chg", 48'(n), 48'd0);
        chk("mid_lost_kc", keycodes, 48'h0);

        send("r22", 8'h22, 1'b0, 1'b0, 1'b0);
        send("p00", 8'h00, 1'b1, 1'b0, 1'b0);
        chk("noop_kc", keycodes, 48'h0);
        chk("noop_cnt", 48'(key_count), 48'd0);

        send("f04", 8'h04, 1'b1, 1'b1, 1'b0);
        send("f07", 8'h07, 1'b1, 1'b1, 1'b0);
        send("f1A", 8'h1A, 1'b1, 1'b1, 1'b0);
        send("f16", 8'h16, 1'b1, 1'b1, 1'b0);
        send("f50", 8'h50, 1'b1, 1'b1, 1'b0);
        send("f4F", 8'h4F, 1'b1, 1'b1, 1'b0);
        chk("full_kc", keycodes, 48'h4F_50_16_1A_07_04);
        chk("full_cnt", 48'(key_count), 48'd6);
`ifdef KEYREPORT_ROLLOVER_EN
        send("o52", 8'h52, 1'b1, 1'b1, 1'b1);
        chk("ovf_kc", keycodes, 48'h01_01_01_01_01_01);
        chk("ovf_cnt", 48'(key_count), 48'd6);
        send("or52", 8'h52, 1'b0, 1'b1, 1'b0);
        chk("restore_kc", keycodes, 48'h4F_50_16_1A_07_04);
`else
        send("o52", 8'h52, 1'b1, 1'b0, 1'b1);
        chk("ovf_kc", keycodes, 48'h4F_50_16_1A_07_04);
        chk("ovf_cnt", 48'(key_count), 48'd6);
        send("or52", 8'h52, 1'b0, 1'b0, 1'b0);
        chk("ign_kc", keycodes, 48'h4F_50_16_1A_07_04);
`endif

        // Back-to-back offers: one acceptance every 8 cycles.
        wait_ready();
        ev_valid   = 1'b1;
        ev_keycode = 8'h16;
        ev_press   = 1'b1;
        n     = 0;
        first = -1;
        last  = -1;
        for (int k = 0; k < 40; k++) begin
            if (ev_ready === 1'b1) begin
                n++;
                if (first < 0) first = k;
                last = k;
            end
            @(negedge Clk);
        end
        ev_valid = 1'b0;
        chk("b2b_accepts", 48'(n), 48'd5);
        chk("b2b_span", 48'(last - first), 48'd32);
        chk("b2b_kc", keycodes, 48'h4F_50_16_1A_07_04);

        send("r04", 8'h04, 1'b0, 1'b1, 1'b0);
        chk("shift_kc", keycodes, 48'h00_4F_50_16_1A_07);
        chk("shift_cnt", 48'(key_count), 48'd5);
        send("r4F", 8'h4F, 1'b0, 1'b1, 1'b0);
        chk("tail_kc", keycodes, 48'h00_00_50_16_1A_07);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

endmodule
